// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer and its datapath.
// The master side drives run/mem_ready/ir; the slave side is the sequencer.
interface control_sequencer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 16
);
   logic                  run;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] ir;

   logic                  pc_out;
   logic                  mar_in;
   logic                  inc_pc;
   logic                  z_in;
   logic                  zlow_out;
   logic                  zhigh_out;
   logic                  pc_in;
   logic                  read;
   logic                  mdr_in;
   logic                  mdr_out;
   logic                  ir_in;
   logic                  y_in;
   logic                  hi_in;
   logic                  lo_in;
   logic [REG_COUNT-1:0]  r_in;
   logic [REG_COUNT-1:0]  r_out;
   logic [4:0]            alu_op;
   logic                  busy;
   logic                  done;
   logic                  illegal;

   modport master (
      output run, mem_ready, ir,
      input  pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read,
             mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in, r_in, r_out, alu_op,
             busy, done, illegal
   );

   modport slave (
      input  run, mem_ready, ir,
      output pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read,
             mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in, r_in, r_out, alu_op,
             busy, done, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch (T0..T2), decode/execute (T3..T6), DONE.
// Strobes are registered, except the T3 decode strobes which follow the ir port.
module control_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 16,
   parameter int REG_SEL_W  = 4
) (
   input  logic                clk,
   input  logic                clr,
   control_sequencer_if.slave  bus
);

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T1W  = 4'd3,
      ST_T2   = 4'd4,
      ST_T3   = 4'd5,
      ST_T4   = 4'd6,
      ST_T5   = 4'd7,
      ST_T6   = 4'd8,
      ST_DONE = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      CLS_TWO    = 2'd0,
      CLS_ONE    = 2'd1,
      CLS_MULDIV = 2'd2,
      CLS_ILL    = 2'd3
   } cls_t;

   typedef struct packed {
      logic                 pc_out;
      logic                 mar_in;
      logic                 inc_pc;
      logic                 z_in;
      logic                 zlow_out;
      logic                 zhigh_out;
      logic                 pc_in;
      logic                 read;
      logic                 mdr_in;
      logic                 mdr_out;
      logic                 ir_in;
      logic                 y_in;
      logic                 hi_in;
      logic                 lo_in;
      logic                 busy;
      logic                 done;
      logic [4:0]           alu_op;
      logic [REG_COUNT-1:0] r_in;
      logic [REG_COUNT-1:0] r_out;
   } strobe_t;

   function automatic logic [REG_COUNT-1:0] onehot(input logic [REG_SEL_W-1:0] idx);
      logic [REG_COUNT-1:0] v;
      for (int i = 0; i < REG_COUNT; i++) begin
         v[i] = (idx == REG_SEL_W'(i));
      end
      return v;
   endfunction

   // A class is legal only if every register field it actually uses names a real register.
   function automatic cls_t classify(input logic [4:0]           opc,
                                     input logic [REG_SEL_W-1:0] ra,
                                     input logic [REG_SEL_W-1:0] rb,
                                     input logic [REG_SEL_W-1:0] rc);
      logic ra_ok;
      logic rb_ok;
      logic rc_ok;
      ra_ok = (int'(ra) < REG_COUNT);
      rb_ok = (int'(rb) < REG_COUNT);
      rc_ok = (int'(rc) < REG_COUNT);
      if ((opc >= 5'd3) && (opc <= 5'd11)) begin
         return (ra_ok && rb_ok && rc_ok) ? CLS_TWO : CLS_ILL;
      end else if ((opc == 5'd15) || (opc == 5'd16)) begin
         return (ra_ok && rb_ok) ? CLS_MULDIV : CLS_ILL;
      end else if ((opc == 5'd17) || (opc == 5'd18)) begin
         return (ra_ok && rb_ok) ? CLS_ONE : CLS_ILL;
      end else begin
         return CLS_ILL;
      end
   endfunction

   state_t               state_q, state_d;
   logic [4:0]           opc_q, opc_d;
   logic [REG_SEL_W-1:0] ra_q, ra_d;
   logic [REG_SEL_W-1:0] rb_q, rb_d;
   logic [REG_SEL_W-1:0] rc_q, rc_d;
   strobe_t              strb_q, strb_d;
   cls_t                 cls_d_s;

   logic [4:0]           ir_opc_s;
   logic [REG_SEL_W-1:0] ir_ra_s;
   logic [REG_SEL_W-1:0] ir_rb_s;
   logic [REG_SEL_W-1:0] ir_rc_s;
   cls_t                 ir_cls_s;
   logic                 unused_ir_s;

   logic [REG_COUNT-1:0] t3_r_out_s;
   logic [4:0]           t3_alu_op_s;
   logic                 t3_y_in_s;
   logic                 t3_z_in_s;
   logic                 t3_illegal_s;

   assign ir_opc_s    = bus.ir[DATA_WIDTH-1 -: 5];
   assign ir_ra_s     = bus.ir[DATA_WIDTH-6 -: REG_SEL_W];
   assign ir_rb_s     = bus.ir[DATA_WIDTH-6-REG_SEL_W -: REG_SEL_W];
   assign ir_rc_s     = bus.ir[DATA_WIDTH-6-2*REG_SEL_W -: REG_SEL_W];
   assign ir_cls_s    = classify(ir_opc_s, ir_ra_s, ir_rb_s, ir_rc_s);
   assign unused_ir_s = ^bus.ir[DATA_WIDTH-6-3*REG_SEL_W:0];

   // Next state, field latch and registered strobes for the state being entered.
   always_comb begin
      state_d = state_q;
      strb_d  = '0;
      if (state_q == ST_T3) begin
         opc_d = ir_opc_s;
         ra_d  = ir_ra_s;
         rb_d  = ir_rb_s;
         rc_d  = ir_rc_s;
      end else begin
         opc_d = opc_q;
         ra_d  = ra_q;
         rb_d  = rb_q;
         rc_d  = rc_q;
      end
      cls_d_s = classify(opc_d, ra_d, rb_d, rc_d);

      case (state_q)
         ST_IDLE: state_d = bus.run ? ST_T0 : ST_IDLE;
         ST_T0:   state_d = ST_T1;
         ST_T1:   state_d = bus.mem_ready ? ST_T2 : ST_T1W;
         ST_T1W:  state_d = bus.mem_ready ? ST_T2 : ST_T1W;
         ST_T2:   state_d = ST_T3;
         ST_T3:   state_d = (ir_cls_s == CLS_ILL) ? ST_DONE : ST_T4;
         ST_T4:   state_d = (cls_d_s == CLS_ONE) ? ST_DONE : ST_T5;
         ST_T5:   state_d = (cls_d_s == CLS_MULDIV) ? ST_T6 : ST_DONE;
         ST_T6:   state_d = ST_DONE;
         ST_DONE: state_d = bus.run ? ST_T0 : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      strb_d.busy = (state_d != ST_IDLE);
      case (state_d)
         ST_T0: begin
            strb_d.pc_out = 1'b1;
            strb_d.mar_in = 1'b1;
            strb_d.inc_pc = 1'b1;
            strb_d.z_in   = 1'b1;
         end
         ST_T1: begin
            strb_d.zlow_out = 1'b1;
            strb_d.pc_in    = 1'b1;
            strb_d.read     = 1'b1;
            strb_d.mdr_in   = 1'b1;
         end
         ST_T1W: begin
            strb_d.read   = 1'b1;
            strb_d.mdr_in = 1'b1;
         end
         ST_T2: begin
            strb_d.mdr_out = 1'b1;
            strb_d.ir_in   = 1'b1;
         end
         ST_T4: begin
            case (cls_d_s)
               CLS_TWO: begin
                  strb_d.r_out  = onehot(rc_d);
                  strb_d.alu_op = opc_d;
                  strb_d.z_in   = 1'b1;
               end
               CLS_ONE: begin
                  strb_d.zlow_out = 1'b1;
                  strb_d.r_in     = onehot(ra_d);
               end
               CLS_MULDIV: begin
                  strb_d.r_out  = onehot(rb_d);
                  strb_d.alu_op = opc_d;
                  strb_d.z_in   = 1'b1;
               end
               default: strb_d.busy = 1'b1;
            endcase
         end
         ST_T5: begin
            case (cls_d_s)
               CLS_TWO: begin
                  strb_d.zlow_out = 1'b1;
                  strb_d.r_in     = onehot(ra_d);
               end
               CLS_MULDIV: begin
                  strb_d.zlow_out = 1'b1;
                  strb_d.lo_in    = 1'b1;
               end
               default: strb_d.busy = 1'b1;
            endcase
         end
         ST_T6: begin
            strb_d.zhigh_out = 1'b1;
            strb_d.hi_in     = 1'b1;
         end
         ST_DONE: strb_d.done = 1'b1;
         default: strb_d.busy = (state_d != ST_IDLE);
      endcase
   end

   // T3 strobes track the ir port so an IR loaded at the end of T2 is decoded at once.
   always_comb begin
      t3_r_out_s   = '0;
      t3_alu_op_s  = 5'd0;
      t3_y_in_s    = 1'b0;
      t3_z_in_s    = 1'b0;
      t3_illegal_s = 1'b0;
      if (state_q == ST_T3) begin
         case (ir_cls_s)
            CLS_TWO: begin
               t3_r_out_s = onehot(ir_rb_s);
               t3_y_in_s  = 1'b1;
            end
            CLS_ONE: begin
               t3_r_out_s  = onehot(ir_rb_s);
               t3_alu_op_s = ir_opc_s;
               t3_z_in_s   = 1'b1;
            end
            CLS_MULDIV: begin
               t3_r_out_s = onehot(ir_ra_s);
               t3_y_in_s  = 1'b1;
            end
            default: t3_illegal_s = 1'b1;
         endcase
      end else begin
         t3_illegal_s = 1'b0;
      end
   end

   // State, latched fields and strobes; clr forces the idle, all-quiet condition.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         opc_q   <= 5'd0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rc_q    <= rc_d;
         strb_q  <= strb_d;
      end
   end

   assign bus.pc_out    = strb_q.pc_out;
   assign bus.mar_in    = strb_q.mar_in;
   assign bus.inc_pc    = strb_q.inc_pc;
   assign bus.z_in      = strb_q.z_in | t3_z_in_s;
   assign bus.zlow_out  = strb_q.zlow_out;
   assign bus.zhigh_out = strb_q.zhigh_out;
   assign bus.pc_in     = strb_q.pc_in;
   assign bus.read      = strb_q.read;
   assign bus.mdr_in    = strb_q.mdr_in;
   assign bus.mdr_out   = strb_q.mdr_out;
   assign bus.ir_in     = strb_q.ir_in;
   assign bus.y_in      = strb_q.y_in | t3_y_in_s;
   assign bus.hi_in     = strb_q.hi_in;
   assign bus.lo_in     = strb_q.lo_in;
   assign bus.r_in      = strb_q.r_in;
   assign bus.r_out     = strb_q.r_out | t3_r_out_s;
   assign bus.alu_op    = strb_q.alu_op | t3_alu_op_s;
   assign bus.busy      = strb_q.busy;
   assign bus.done      = strb_q.done;
   assign bus.illegal   = t3_illegal_s;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter REG_COUNT, default 16: number of general registers, range 2..16.
REQ-003 SHALL have parameter REG_SEL_W, default 4: register-field width; REG_COUNT SHALL NOT exceed 2^REG_SEL_W.
REQ-004 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port clr  in  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have port run  in  1  start or continue instruction execution.
REQ-007 SHALL have port mem_ready  in  1  memory read data valid on Mdatain.
REQ-008 SHALL have port ir  in  DATA_WIDTH  current IR contents.
REQ-009 SHALL have outputs pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in, each 1 bit, each a datapath strobe.
REQ-010 SHALL have outputs r_in, r_out, each REG_COUNT bits, one-hot register enables.
REQ-011 SHALL have outputs alu_op (5 bits), busy, done, illegal (1 bit each).

Function
REQ-012 Fields SHALL be: opc = ir[DATA_WIDTH-1 -: 5]; ra, rb, rc = the next three REG_SEL_W-bit fields below opc, in that order.
REQ-013 Classes SHALL be: opc 3..11 two-operand; 15..16 mul/div; 17..18 one-operand; all other opc illegal.
REQ-014 An instruction SHALL also be illegal if any field its class uses is >= REG_COUNT.
REQ-015 States SHALL be IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, DONE.
REQ-016 IDLE -> T0 SHALL occur when run=1; otherwise the block SHALL remain in IDLE.
REQ-017 T0 SHALL assert pc_out, mar_in, inc_pc and z_in, then go to T1.
REQ-018 T1 SHALL assert zlow_out, pc_in, read and mdr_in, then go to T2 if mem_ready=1, else to T1W.
REQ-019 T1W SHALL assert read and mdr_in only, and SHALL stay in T1W until mem_ready=1, then go to T2; pc_in SHALL never repeat.
REQ-020 T2 SHALL assert mdr_out and ir_in, then go to T3.
REQ-021 T3 SHALL decode from the ir port directly and latch opc/ra/rb/rc on exit; later states SHALL use the latched copy only.
REQ-022 Two-operand: T3 r_out[rb], y_in; T4 r_out[rc], alu_op=opc, z_in; T5 zlow_out, r_in[ra]; then DONE.
REQ-023 One-operand: T3 r_out[rb], alu_op=opc, z_in; T4 zlow_out, r_in[ra]; then DONE.
REQ-024 Mul/div: T3 r_out[ra], y_in; T4 r_out[rb], alu_op=opc, z_in; T5 zlow_out, lo_in; T6 zhigh_out, hi_in; then DONE.
REQ-025 Illegal: T3 SHALL pulse illegal for one cycle with no other strobe, then go to DONE.
REQ-026 DONE SHALL pulse done for one cycle, then go to T0 if run=1, else to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 alu_op SHALL be 0 outside the ALU step.
REQ-029 At most one bus driver (pc_out, zlow_out, zhigh_out, mdr_out, any r_out bit) SHALL be asserted per cycle.
REQ-030 run SHALL be sampled only in IDLE and DONE; deasserting it mid-instruction SHALL NOT abort the instruction.
REQ-031 Latency from IDLE exit to done, with zero wait states, SHALL be: 7 cycles two-operand, 6 one-operand, 8 mul/div, 5 illegal; each T1W cycle SHALL add one cycle.

Reset
REQ-032 clr=0 at a rising clk edge SHALL force IDLE, clear latched fields and drive every output to 0 from that edge, in any state including T1W.
REQ-033 After clr returns to 1, the block SHALL stay in IDLE until run=1 is sampled.

Verification
REQ-034 ir=0x90080000 (not R0,R1), mem_ready=1, run pulse -> T3 r_out=0x0002, alu_op=18, z_in; T4 zlow_out, r_in=0x0001; done in the 6th cycle.
REQ-035 ir=0x191A0000 (add R2,R3,R4) -> T3 r_out[3]+y_in; T4 r_out[4], alu_op=3; T5 r_in[2]; done in the 7th cycle.
REQ-036 mem_ready low for 3 cycles after T1 -> read/mdr_in high 4 consecutive cycles, pc_in high exactly 1 cycle, done delayed 3 cycles.
REQ-037 ir=0x7AB00000 (mul R5,R6) -> T5 zlow_out+lo_in; T6 zhigh_out+hi_in; no r_in bit set; done in the 8th cycle.
REQ-038 ir=0x00000000 (opc 0) -> illegal pulse in T3, r_in stays 0, done next cycle.
REQ-039 clr=0 during T4 of add; run held 1 across two instructions -> after the reset edge all outputs 0, no r_in; back-to-back run gives DONE -> T0 with no IDLE cycle.
